// File: rtl/commit_trace_buffer_if.sv
// Capture and readout bundle for commit_trace_buffer.
// Capture: a commit is taken on any cycle with cap_valid=1 (no back-pressure).
// Readout: an entry moves on a cycle where rd_valid && rd_ready. While rd_valid=1
// and rd_ready=0, all rd_* signals hold. rd_* read as 0 whenever rd_valid=0.
interface commit_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_instr;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_wdata;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [4:0]      rd_rd;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_last;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_rd, cap_wdata, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_rd, rd_wdata, rd_last
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_rd, cap_wdata, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_rd, rd_wdata, rd_last
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular commit trace buffer with a PC-match trigger, post-trigger capture
// and oldest-first drain over a valid/ready port.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  commit_trace_buffer_if.slave tr,
  input  logic                 arm,
  input  logic                 trig_en,
  input  logic [XLEN-1:0]      trig_pc,
  input  logic [PTR_W:0]       post_cnt,
  output logic [1:0]           state,
  output logic [PTR_W:0]       count,
  output logic                 overflow
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] MAX_POST = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  state_t           state_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] remaining;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [4:0]      mem_rd    [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];

  logic             cap_fire;
  logic             trig_hit;
  logic [PTR_W:0]   post_clamp;
  logic [PTR_W-1:0] wr_ptr_nx;
  logic             ovf_nx;

  assign cap_fire   = tr.cap_valid && !arm && (state_q == ARMED || state_q == POST);
  assign trig_hit   = (state_q == ARMED) && trig_en && tr.cap_valid && (tr.cap_pc == trig_pc);
  // Clamp keeps the trigger entry from being overwritten by post-trigger commits.
  assign post_clamp = (post_cnt > MAX_POST) ? MAX_POST : post_cnt;
  assign wr_ptr_nx  = wr_ptr + 1'b1;
  assign ovf_nx     = overflow || (count == FULL);

  always_ff @(posedge clk) begin
    if (cap_fire) begin
      mem_pc[wr_ptr]    <= tr.cap_pc;
      mem_instr[wr_ptr] <= tr.cap_instr;
      mem_rd[wr_ptr]    <= tr.cap_rd;
      mem_wdata[wr_ptr] <= tr.cap_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else if (arm) begin
      state_q  <= ARMED;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED, POST: begin
          if (tr.cap_valid) begin
            wr_ptr <= wr_ptr_nx;
            if (count == FULL) overflow <= 1'b1;
            else               count    <= count + 1'b1;
            if (state_q == POST) begin
              remaining <= remaining - 1'b1;
              if (remaining == PTR_W'(1)) begin
                state_q <= DONE;
                rd_ptr  <= ovf_nx ? wr_ptr_nx : '0;
              end
            end else if (trig_hit) begin
              remaining <= post_clamp[PTR_W-1:0];
              if (post_clamp == '0) begin
                state_q <= DONE;
                rd_ptr  <= ovf_nx ? wr_ptr_nx : '0;
              end else begin
                state_q <= POST;
              end
            end
          end
        end
        DONE: begin
          if (tr.rd_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (count == ONE) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign tr.rd_valid = (state_q == DONE);
  assign tr.rd_pc    = tr.rd_valid ? mem_pc[rd_ptr]    : '0;
  assign tr.rd_instr = tr.rd_valid ? mem_instr[rd_ptr] : '0;
  assign tr.rd_rd    = tr.rd_valid ? mem_rd[rd_ptr]    : '0;
  assign tr.rd_wdata = tr.rd_valid ? mem_wdata[rd_ptr] : '0;
  assign tr.rd_last  = tr.rd_valid && (count == ONE);
endmodule
